// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a one-entry registered output stage.
// Ops other than DIVU/REMU complete in one cycle. DIVU/REMU run on a
// restoring divider that makes one quotient bit per cycle.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       flags
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(32'd0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(32'd1);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(32'd2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(32'd3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(32'd4);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(32'd5);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(32'd6);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(32'd7);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(32'd8);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(32'd9);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(32'd10);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(32'd11);
    localparam logic [OPW-1:0] OP_REMU = OPW'(32'd12);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    // Flag vector {err, ovf, carry, neg, zero} derived from a result word.
    function automatic logic [4:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic err,
                                              input logic ovf,
                                              input logic carry);
        make_flags = {err, ovf, carry, res[WIDTH-1], (res == {WIDTH{1'b0}})};
    endfunction

    state_t                 state_r, state_next_s;
    logic                   accept_s;
    logic                   is_div_op_s;
    logic                   illegal_s;
    logic [WIDTH:0]         sum_s;
    logic [WIDTH:0]         dif_s;
    logic [2*WIDTH-1:0]     prod_s;
    logic [SHW-1:0]         shamt_s;
    logic [WIDTH-1:0]       sra_s;
    logic [WIDTH-1:0]       alu_res_s;
    logic                   alu_err_s, alu_ovf_s, alu_carry_s;
    logic [4:0]             alu_flags_s;

    logic [WIDTH-1:0]       rem_r, quo_r, dvs_r;
    logic                   is_rem_r;
    logic [CNTW-1:0]        cnt_r;
    logic [WIDTH:0]         trial_s, sub_s;
    logic [WIDTH-1:0]       rem_next_s, quo_next_s;
    logic                   div_done_s, div_zero_s;
    logic [WIDTH-1:0]       div_res_s;
    logic [4:0]             div_flags_s;

    // Ready only when idle and the output slot is free or retiring; held low in reset.
    assign in_ready    = !rst && (state_r == IDLE) && (!out_valid || out_ready);
    assign accept_s    = in_valid && in_ready;
    assign is_div_op_s = (Op == OP_DIVU) || (Op == OP_REMU);

    // Single-cycle datapath for all non-divide opcodes.
    always_comb begin
        sum_s       = {1'b0, A} + {1'b0, B};
        dif_s       = {1'b0, A} - {1'b0, B};
        prod_s      = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        shamt_s     = B[SHW-1:0];
        sra_s       = $signed(A) >>> shamt_s;
        alu_res_s   = {WIDTH{1'b0}};
        alu_err_s   = 1'b0;
        alu_ovf_s   = 1'b0;
        alu_carry_s = 1'b0;
        illegal_s   = 1'b0;
        case (Op)
            OP_ADD: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s   = dif_s[WIDTH-1:0];
                alu_carry_s = !dif_s[WIDTH];
                alu_ovf_s   = (A[WIDTH-1] != B[WIDTH-1]) && (dif_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MUL: begin
                alu_res_s = prod_s[WIDTH-1:0];
                alu_ovf_s = |prod_s[2*WIDTH-1:WIDTH];
            end
            OP_AND:  alu_res_s = A & B;
            OP_OR:   alu_res_s = A | B;
            OP_XOR:  alu_res_s = A ^ B;
            OP_SLL:  alu_res_s = A << shamt_s;
            OP_SRL:  alu_res_s = A >> shamt_s;
            OP_SRA:  alu_res_s = sra_s;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_DIVU: alu_res_s = {WIDTH{1'b0}};
            OP_REMU: alu_res_s = {WIDTH{1'b0}};
            default: begin
                alu_err_s = 1'b1;
                illegal_s = 1'b1;
            end
        endcase
        // Illegal opcodes report err alone; zero is deliberately suppressed.
        if (illegal_s) begin
            alu_flags_s = 5'b10000;
        end else begin
            alu_flags_s = make_flags(alu_res_s, alu_err_s, alu_ovf_s, alu_carry_s);
        end
    end

    // Restoring divider step: quo_r shifts the dividend out at the top and quotient bits in at the bottom.
    always_comb begin
        trial_s = {rem_r, quo_r[WIDTH-1]};
        sub_s   = trial_s - {1'b0, dvs_r};
        if (!sub_s[WIDTH]) begin
            rem_next_s = sub_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
        div_done_s = (state_r == DIV) && (cnt_r == CNTW'(WIDTH));
        div_zero_s = (dvs_r == {WIDTH{1'b0}});
        // With a zero divisor the remainder naturally ends up equal to A; the quotient is forced.
        if (is_rem_r) begin
            div_res_s = rem_r;
        end else if (div_zero_s) begin
            div_res_s = {WIDTH{1'b1}};
        end else begin
            div_res_s = quo_r;
        end
        div_flags_s = make_flags(div_res_s, div_zero_s, 1'b0, 1'b0);
    end

    // Next-state logic: divides occupy DIV for WIDTH iterations plus one result-load cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_div_op_s) begin
                    state_next_s = DIV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DIV;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Divider working registers: loaded on a divide acceptance, stepped while iterating.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            is_rem_r <= 1'b0;
            cnt_r    <= {CNTW{1'b0}};
        end else if (accept_s && is_div_op_s) begin
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= A;
            dvs_r    <= B;
            is_rem_r <= (Op == OP_REMU);
            cnt_r    <= {CNTW{1'b0}};
        end else if ((state_r == DIV) && !div_done_s) begin
            rem_r    <= rem_next_s;
            quo_r    <= quo_next_s;
            cnt_r    <= cnt_r + CNTW'(1);
        end
    end

    // Output register: load on single-cycle accept or divide completion, clear on retire, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Result    <= {WIDTH{1'b0}};
            flags     <= 5'b00000;
        end else if (accept_s) begin
            if (is_div_op_s) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                Result    <= alu_res_s;
                flags     <= alu_flags_s;
            end
        end else if (div_done_s) begin
            out_valid <= 1'b1;
            Result    <= div_res_s;
            flags     <= div_flags_s;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=32): directed scenarios followed by a
// randomized run scored against an arithmetic reference model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Op(op), .out_valid(out_valid), .out_ready(out_ready),
        .Result(result), .flags(flags)
    );

    // Reference model: returns {flags, result} from the opcode definitions using wide arithmetic.
    function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        logic [63:0]        ux   = {32'd0, x};
        logic [63:0]        uy   = {32'd0, y};
        logic signed [63:0] sx   = {{32{x[31]}}, x};
        logic signed [63:0] sy   = {{32{y[31]}}, y};
        logic [63:0]        full = 64'd0;
        logic signed [63:0] s    = 64'sd0;
        logic [31:0]        r    = 32'd0;
        logic               err  = 1'b0;
        logic               ovf  = 1'b0;
        logic               cy   = 1'b0;
        logic [4:0]         f;
        case (o)
            4'd0: begin
                full = ux + uy; r = full[31:0]; cy = full[32];
                s = sx + sy; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                full = ux - uy; r = full[31:0]; cy = (ux >= uy);
                s = sx - sy; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: begin
                full = ux * uy; r = full[31:0]; ovf = (full > 64'd4294967295);
            end
            4'd3: r = x & y;
            4'd4: r = x | y;
            4'd5: r = x ^ y;
            4'd6: r = x << y[4:0];
            4'd7: r = x >> y[4:0];
            4'd8: r = $signed(x) >>> y[4:0];
            4'd9: r = (sx < sy) ? 32'd1 : 32'd0;
            4'd10: r = (ux < uy) ? 32'd1 : 32'd0;
            4'd11: begin
                if (uy == 64'd0) begin r = 32'hFFFF_FFFF; err = 1'b1; end
                else begin full = ux / uy; r = full[31:0]; end
            end
            4'd12: begin
                if (uy == 64'd0) begin r = x; err = 1'b1; end
                else begin full = ux % uy; r = full[31:0]; end
            end
            default: err = 1'b1;
        endcase
        if (o > 4'd12) f = 5'b10000;
        else f = {err, ovf, cy, r[31], (r == 32'd0)};
        return {f, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation and hold in_valid until it is accepted; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        int n = 0;
        a = x; b = y; op = o; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // After a divide is accepted, count edges until out_valid and cycles with in_ready low.
    task automatic div_wait(output int edges, output int low);
        edges = 0; low = 0;
        while (!out_valid && edges < 100) begin
            if (!in_ready) low++;
            @(posedge clk); #1; edges++;
        end
    endtask

    // One random-phase cycle: score a retiring result, record an accepted op, then advance.
    task automatic rand_cycle();
        logic [36:0] e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rand_result", {32'd0, result}, {32'd0, e[31:0]});
                chk("rand_flags", {59'd0, flags}, {59'd0, e[36:32]});
            end
        end
        if (out_valid && !out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
        @(posedge clk); #1;
    endtask

    initial begin
        int edges, low, hi_cnt, sel, n;

        // Reset with an operation offered: nothing may be accepted.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 32'd1; b = 32'd2; op = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_flags", {59'd0, flags}, 64'd0);
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        // Basic add / sub with latency 1.
        send(32'd10, 32'd5, 4'd0);
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_result", {32'd0, result}, 64'd15);
        chk("add_flags", {59'd0, flags}, 64'b00000);
        send(32'd15, 32'd10, 4'd1);
        chk("sub_result", {32'd0, result}, 64'd5);
        chk("sub_flags", {59'd0, flags}, 64'b00100);

        // Add overflow and carry-out boundaries; multiply overflow.
        send(32'h7FFF_FFFF, 32'd1, 4'd0);
        chk("ovf_result", {32'd0, result}, 64'h8000_0000);
        chk("ovf_flags", {59'd0, flags}, 64'b01010);
        send(32'hFFFF_FFFF, 32'd1, 4'd0);
        chk("carry_result", {32'd0, result}, 64'd0);
        chk("carry_flags", {59'd0, flags}, 64'b00101);
        send(32'h0001_0000, 32'h0001_0000, 4'd2);
        chk("mul_flags", {59'd0, flags}, 64'b01001);

        // Divide latency, remainder, divide by zero.
        send(32'd100, 32'd7, 4'd11);
        chk("div_start_valid", {63'd0, out_valid}, 64'd0);
        div_wait(edges, low);
        chk("div_latency", edges, 64'd33);
        chk("div_busy_cycles", low, 64'd33);
        chk("divu_result", {32'd0, result}, 64'd14);
        send(32'd100, 32'd7, 4'd12);
        div_wait(edges, low);
        chk("remu_result", {32'd0, result}, 64'd2);
        send(32'd100, 32'd0, 4'd11);
        div_wait(edges, low);
        chk("div0_latency", edges, 64'd33);
        chk("div0_result", {32'd0, result}, 64'hFFFF_FFFF);
        chk("div0_flags", {59'd0, flags}, 64'b10010);
        send(32'd100, 32'd0, 4'd12);
        div_wait(edges, low);
        chk("rem0_result", {32'd0, result}, 64'd100);
        chk("rem0_flags", {59'd0, flags}, 64'b10000);

        // Illegal opcode, then a legal AND clears err.
        send(32'd5, 32'd6, 4'd14);
        chk("illegal_result", {32'd0, result}, 64'd0);
        chk("illegal_flags", {59'd0, flags}, 64'b10000);
        send(32'h0000_00F0, 32'h0000_003C, 4'd3);
        chk("and_result", {32'd0, result}, 64'h30);
        chk("and_err", {63'd0, flags[4]}, 64'd0);

        // Backpressure: second add held off while the first result stalls.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'd1, 32'd2, 4'd0);
        a = 32'd3; b = 32'd4; op = 4'd0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_result", {32'd0, result}, 64'd3);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            a = 32'd99; @(posedge clk); #1; a = 32'd3;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_second_result", {32'd0, result}, 64'd7);
        @(posedge clk); #1;
        chk("bp_no_dup", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of a division abandons it.
        send(32'd1000, 32'd3, 4'd11);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_result", {32'd0, result}, 64'd0);
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) hi_cnt++;
            @(posedge clk); #1;
        end
        chk("midrst_no_output", hi_cnt, 64'd0);
        send(32'd2, 32'd3, 4'd0);
        chk("midrst_add_valid", {63'd0, out_valid}, 64'd1);
        chk("midrst_add_result", {32'd0, result}, 64'd5);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure, scored in order.
        for (int t = 0; t < 1500; t++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            sel = $urandom_range(0, 99);
            if (sel < 6) op = 4'd11;
            else if (sel < 12) op = 4'd12;
            else op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0) b = 32'($urandom_range(0, 40));
            else if (sel == 1) b = 32'd0;
            else b = $urandom;
            out_ready = ($urandom_range(0, 99) < 70);
            rand_cycle();
        end

        // Drain whatever is still in flight.
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            rand_cycle();
            n++;
        end
        chk("drain_empty", exp_q.size(), 64'd0);
        chk("drain_idle", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
